// File: rtl/alu_op_fifo.sv
// Operand/command FIFO in front of the 32-bit ALU. It is first-word-fall-through,
// and the head outputs are forced to zero while the FIFO is empty.
module alu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_src1,
    input  logic [31:0]   in_src2,
    input  logic [3:0]    in_alu_ctrl,
    input  logic [2:0]    in_bonus_ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   src1,
    output logic [31:0]   src2,
    output logic [3:0]    ALU_control,
    output logic [2:0]    bonus_control,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  alu_ctrl;
        logic [2:0]  bonus_ctrl;
    } entry_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic          push, pop, wr_en;

    // Readiness depends only on the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{src1: in_src1, src2: in_src2,
                                 alu_ctrl: in_alu_ctrl, bonus_ctrl: in_bonus_ctrl};
        end
    end

    assign head          = out_valid ? mem_q[rd_ptr_q] : '0;
    assign src1          = head.src1;
    assign src2          = head.src2;
    assign ALU_control   = head.alu_ctrl;
    assign bonus_control = head.bonus_ctrl;
    assign count         = count_q;

endmodule
